// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit that validates, sizes and masks one access,
// drives the data memory for a single cycle and returns a registered response.
module lsu_mem_stage #(
    parameter int MEM_BYTES = 128,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [4:0]       req_rd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [4:0]       rsp_rd,
    output logic [1:0]       rsp_err,
    output logic [31:0]      dm_addr,
    output logic             dm_we,
    output logic             dm_re,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata,
    output logic [CNT_W-1:0] cnt_ld,
    output logic [CNT_W-1:0] cnt_st,
    output logic [CNT_W-1:0] cnt_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, data_q, ld_data;
    logic [4:0]  rd_q;
    logic [1:0]  err_q, err;
    logic [2:0]  size;
    logic [32:0] last;
    logic        illegal, misal, acc;

    // Classify the incoming request; range end is computed in 33 bits so it cannot wrap
    always_comb begin
        size    = req_funct3[1:0] == 2'b00 ? 3'd1 : req_funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
        last    = {1'b0, req_addr} + {30'd0, size} - 33'd1;
        illegal = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]);
        misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                  (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        err     = illegal ? 2'b11 : misal ? 2'b01 : last >= 33'(MEM_BYTES) ? 2'b10 : 2'b00;
    end

    // Sign/zero-extend the addressed load data according to the latched size
    always_comb begin
        ld_data = dm_rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
            3'b001:  ld_data = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
            3'b100:  ld_data = {24'd0, dm_rdata[7:0]};
            3'b101:  ld_data = {16'd0, dm_rdata[15:0]};
            default: ld_data = dm_rdata;
        endcase
    end

    // State register; reset drops out of ACCESS at once so a store is abandoned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state: errors skip the memory access and go straight to the response
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? (err != 2'b00 ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, response capture and saturating completion counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= '0;
            data_q  <= '0;
            cnt_ld  <= '0;
            cnt_st  <= '0;
            cnt_err <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                err_q   <= err;
                data_q  <= '0;
            end
            if (state == ACCESS) data_q <= we_q ? '0 : ld_data;
            if (state == RESP && rsp_ready) begin
                if (err_q != 2'b00) cnt_err <= cnt_err + {{(CNT_W-1){1'b0}}, ~&cnt_err};
                else if (we_q)      cnt_st  <= cnt_st + {{(CNT_W-1){1'b0}}, ~&cnt_st};
                else                cnt_ld  <= cnt_ld + {{(CNT_W-1){1'b0}}, ~&cnt_ld};
            end
        end
    end

    assign acc       = state == ACCESS;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_data  = data_q;
    assign rsp_rd    = rd_q;
    assign rsp_err   = err_q;
    assign dm_addr   = acc ? addr_q : '0;
    assign dm_we     = acc && we_q;
    assign dm_re     = acc && !we_q;
    assign dm_wdata  = acc ? wdata_q : '0;
    assign dm_be     = !acc ? 4'b0000 : f3_q[1:0] == 2'b00 ? 4'b0001 : f3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed vector table plus stall and mid-access reset sequences.
module tb_lsu_mem_stage;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready, rsp_valid, dm_we, dm_re;
    logic [31:0] rsp_data, dm_addr, dm_wdata, dm_rdata;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_err;
    logic [3:0]  dm_be;
    logic [15:0] cnt_ld, cnt_st, cnt_err;
    logic [7:0]  mem [128];
    logic [6:0]  ra;
    int checks = 0, errors = 0;
    int e_ld = 0, e_st = 0, e_err = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        logic [3:0]  exp_be;
    } vec_t;
    vec_t v [19];

    lsu_mem_stage #(.MEM_BYTES(128), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rsp_err(rsp_err), .dm_addr(dm_addr), .dm_we(dm_we), .dm_re(dm_re), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    // Byte-addressed data memory model with byte-enable writes
    assign ra = dm_addr[6:0];
    assign dm_rdata = {mem[ra + 7'd3], mem[ra + 7'd2], mem[ra + 7'd1], mem[ra]};
    always @(posedge clk) begin
        if (dm_we)
            for (int b = 0; b < 4; b++)
                if (dm_be[b]) mem[ra + 7'(b)] = dm_wdata[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_cnt();
        chk("cnt_ld", 32'(cnt_ld), 32'(e_ld));
        chk("cnt_st", 32'(cnt_st), 32'(e_st));
        chk("cnt_err", 32'(cnt_err), 32'(e_err));
    endtask

    task automatic run_vec(input vec_t t);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = t.we; req_funct3 = t.f3;
        req_addr = t.addr; req_wdata = t.wdata; req_rd = t.rd;
        @(negedge clk);
        req_valid = 1'b0;
        if (t.exp_err != 2'b00) begin
            chk("err_rsp_valid_n1", 32'(rsp_valid), 32'd1);
            chk("err_no_dm", {29'd0, dm_re, dm_we, |dm_be}, 32'd0);
        end else begin
            chk("ok_rsp_valid_n1", 32'(rsp_valid), 32'd0);
            chk("dm_be", 32'(dm_be), 32'(t.exp_be));
            chk("dm_we_re", {30'd0, dm_we, dm_re}, {30'd0, t.we, !t.we});
            chk("dm_addr", dm_addr, t.addr);
            if (t.we) chk("dm_wdata", dm_wdata, t.wdata);
            @(negedge clk);
            chk("ok_rsp_valid_n2", 32'(rsp_valid), 32'd1);
            chk("resp_no_dm", {29'd0, dm_re, dm_we, |dm_be}, 32'd0);
        end
        chk("rsp_data", rsp_data, t.exp_data);
        chk("rsp_rd", 32'(rsp_rd), 32'(t.rd));
        chk("rsp_err", 32'(rsp_err), 32'(t.exp_err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        if (t.exp_err != 2'b00) e_err++;
        else if (t.we) e_st++;
        else e_ld++;
        chk_cnt();
    endtask

    initial begin
        vec_t t;
        logic [31:0] held;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        //        we    f3      addr          wdata         rd     exp_data      err    be
        v[0]  = '{1'b1, 3'b010, 32'h10,       32'hA1B2C3D4, 5'd1,  32'h0,        2'b00, 4'hF};
        v[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        5'd2,  32'hA1B2C3D4, 2'b00, 4'hF};
        v[2]  = '{1'b1, 3'b000, 32'h21,       32'h80,       5'd3,  32'h0,        2'b00, 4'h1};
        v[3]  = '{1'b0, 3'b000, 32'h21,       32'h0,        5'd4,  32'hFFFFFF80, 2'b00, 4'h1};
        v[4]  = '{1'b0, 3'b100, 32'h21,       32'h0,        5'd5,  32'h00000080, 2'b00, 4'h1};
        v[5]  = '{1'b1, 3'b001, 32'h22,       32'h8001,     5'd6,  32'h0,        2'b00, 4'h3};
        v[6]  = '{1'b0, 3'b001, 32'h22,       32'h0,        5'd7,  32'hFFFF8001, 2'b00, 4'h3};
        v[7]  = '{1'b0, 3'b101, 32'h22,       32'h0,        5'd8,  32'h00008001, 2'b00, 4'h3};
        v[8]  = '{1'b0, 3'b001, 32'h13,       32'h0,        5'd9,  32'h0,        2'b01, 4'h0};
        v[9]  = '{1'b0, 3'b010, 32'h7E,       32'h0,        5'd10, 32'h0,        2'b01, 4'h0};
        v[10] = '{1'b1, 3'b010, 32'h7C,       32'h12345678, 5'd11, 32'h0,        2'b00, 4'hF};
        v[11] = '{1'b0, 3'b010, 32'h7C,       32'h0,        5'd12, 32'h12345678, 2'b00, 4'hF};
        v[12] = '{1'b0, 3'b010, 32'h80,       32'h0,        5'd13, 32'h0,        2'b10, 4'h0};
        v[13] = '{1'b0, 3'b001, 32'hFFFFFFFE, 32'h0,        5'd14, 32'h0,        2'b10, 4'h0};
        v[14] = '{1'b0, 3'b011, 32'h13,       32'h0,        5'd15, 32'h0,        2'b11, 4'h0};
        v[15] = '{1'b1, 3'b100, 32'h0,        32'h5,        5'd16, 32'h0,        2'b11, 4'h0};
        v[16] = '{1'b0, 3'b001, 32'h7F,       32'h0,        5'd17, 32'h0,        2'b01, 4'h0};
        v[17] = '{1'b0, 3'b000, 32'h7F,       32'h0,        5'd18, 32'h00000012, 2'b00, 4'h1};
        v[18] = '{1'b0, 3'b001, 32'h7E,       32'h0,        5'd19, 32'h00001234, 2'b00, 4'h3};

        #2;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_outputs", {26'd0, rsp_valid, dm_we, dm_re, |dm_be, |dm_addr, |rsp_data}, 32'd0);
        chk_cnt();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(v[i]);

        // Response stall with a competing request held on the input
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd20;
        @(negedge clk);
        req_addr = 32'h20;
        chk("stall_access_addr", dm_addr, 32'h10);
        @(negedge clk);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        held = rsp_data;
        chk("stall_data", held, 32'hA1B2C3D4);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_hold_data", rsp_data, 32'hA1B2C3D4);
            chk("stall_hold_rd", 32'(rsp_rd), 32'd20);
            chk("stall_flags", {28'd0, rsp_valid, req_ready, dm_re, dm_we}, 32'h8);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        e_ld++;
        chk_cnt();

        // Reset asserted while a store is in its memory cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30;
        req_wdata = 32'hDEADBEEF; req_rd = 5'd21;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_pre_we", 32'(dm_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_we_drop", {29'd0, dm_we, |dm_be, rsp_valid}, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mem_kept", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h33323130);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        e_ld = 0; e_st = 0; e_err = 0;
        chk_cnt();
        t = '{1'b0, 3'b010, 32'h30, 32'h0, 5'd22, 32'h33323130, 2'b00, 4'hF};
        run_vec(t);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
